// File: rtl/instruction_fetch_buffer_pkg.sv
// rtl/instruction_fetch_buffer_pkg.sv - shared types and constants for the fetch buffer
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } fetch_state_t;

  // Tag carried alongside every accepted fetch, faulted or not
  typedef struct packed {
    logic [31:0] pc;
    logic        misaligned;
    logic        out_of_range;
  } fetch_entry_t;

  // Tag plus the instruction word, as held in the output buffer
  typedef struct packed {
    logic [31:0]  data;
    fetch_entry_t tag;
  } fetch_data_entry_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h00000013;

  function automatic logic entry_faulted(input fetch_entry_t e);
    return e.misaligned || e.out_of_range;
  endfunction

endpackage

// File: rtl/instruction_fetch_buffer_if.sv
// rtl/instruction_fetch_buffer_if.sv - PC, decode, load and memory signals of the fetch buffer
interface instruction_fetch_buffer_if #(
  parameter int ADDR_W = 8
);
  logic              pc_valid;
  logic              pc_ready;
  logic [31:0]       pc_address;
  logic              flush;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_data;
  logic [31:0]       instr_pc;
  logic              instr_misaligned;
  logic              instr_out_of_range;
  logic              load_mode;
  logic              load_active;
  logic              load_write;
  logic [31:0]       load_address;
  logic [31:0]       load_data;
  logic              imem_read_enable;
  logic              imem_write_enable;
  logic [ADDR_W-1:0] imem_address;
  logic [31:0]       imem_write_data;
  logic [31:0]       imem_read_data;

  // The fetch buffer itself
  modport master (
    input  pc_valid, pc_address, flush, instr_ready,
    input  load_mode, load_write, load_address, load_data, imem_read_data,
    output pc_ready, instr_valid, instr_data, instr_pc, instr_misaligned, instr_out_of_range,
    output load_active, imem_read_enable, imem_write_enable, imem_address, imem_write_data
  );

  // PC stage, decode, loader and memory around it
  modport slave (
    output pc_valid, pc_address, flush, instr_ready,
    output load_mode, load_write, load_address, load_data, imem_read_data,
    input  pc_ready, instr_valid, instr_data, instr_pc, instr_misaligned, instr_out_of_range,
    input  load_active, imem_read_enable, imem_write_enable, imem_address, imem_write_data
  );
endinterface

// File: rtl/instruction_fetch_buffer_fifo.sv
// rtl/instruction_fetch_buffer_fifo.sv - small power-of-two FIFO holding fetched instructions
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t           slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign head_valid = count != '0;
  assign head       = slots[rd_ptr];
  assign do_pop     = pop && head_valid;

  // Pointers and occupancy; flush wins over a same-cycle push or pop
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(do_pop);
    end
  end

  // Storage is not reset; only slots below count are ever observed
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) slots[wr_ptr] <= push_entry;
  end

  // The issue credit check upstream must keep a push away from a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && count == (PTR_W + 1)'(DEPTH)));

endmodule

// File: rtl/instruction_fetch_buffer.sv
// rtl/instruction_fetch_buffer.sv - PC-to-memory fetch adapter with latency tracking and program load
module instruction_fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int          MEMORY_SIZE         = 1024,
  parameter int          MEMORY_ADDRESS_BITS = $clog2(MEMORY_SIZE),
  parameter int          READ_LATENCY        = 1,
  parameter int          FIFO_DEPTH          = 4,
  parameter logic [31:0] NOP_INSTRUCTION     = NOP_DEFAULT
) (
  input logic                        clk,
  input logic                        reset,
  instruction_fetch_buffer_if.master bus
);
  localparam int AW    = MEMORY_ADDRESS_BITS;
  localparam int CNT_W = 6;

  fetch_state_t                state;
  logic                        load_active_q;
  logic [READ_LATENCY-1:0]     stage_valid;
  fetch_entry_t                stage_entry [READ_LATENCY];
  fetch_entry_t                issue_entry;
  fetch_data_entry_t           push_entry;
  fetch_data_entry_t           fifo_head;
  logic                        fifo_head_valid;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [CNT_W-1:0]            inflight;
  logic                        pc_ready;
  logic                        accept;
  logic                        read_enable;
  logic                        push;
  logic                        pop;
  logic                        unused_load_bits;

  // Fault classification of the incoming PC; out-of-range uses the full 32-bit value
  always_comb begin
    issue_entry.pc           = bus.pc_address;
    issue_entry.misaligned   = bus.pc_address[1:0] != 2'b00;
    issue_entry.out_of_range = bus.pc_address >= 32'(MEMORY_SIZE);
  end

  // Every accepted request holds a slot from issue until decode pops it
  assign inflight    = CNT_W'($countones(stage_valid));
  assign pc_ready    = !reset && state == FETCH && !bus.flush &&
                       (inflight + CNT_W'(fifo_count) < CNT_W'(FIFO_DEPTH));
  assign accept      = bus.pc_valid && pc_ready;
  assign read_enable = accept && !entry_faulted(issue_entry);

  // Mode sequencing: outstanding reads retire before the loader owns the memory port
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      load_active_q <= 1'b0;
    end else begin
      unique case (state)
        FETCH: if (bus.load_mode) state <= DRAIN;
        DRAIN: if (inflight == '0) begin
          state         <= LOAD;
          load_active_q <= 1'b1;
        end
        LOAD: if (!bus.load_mode) begin
          state         <= FETCH;
          load_active_q <= 1'b0;
        end
        default: begin
          state         <= FETCH;
          load_active_q <= 1'b0;
        end
      endcase
    end
  end

  // Latency pipeline keeps tags aligned with returning read data; a fetch-mode flush kills it
  always_ff @(posedge clk) begin
    if (reset || (bus.flush && state == FETCH)) begin
      stage_valid <= '0;
    end else begin
      stage_valid[0] <= accept;
      stage_entry[0] <= issue_entry;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_entry[i] <= stage_entry[i-1];
      end
    end
  end

  assign push           = stage_valid[READ_LATENCY-1];
  assign push_entry.tag = stage_entry[READ_LATENCY-1];
  assign push_entry.data = entry_faulted(stage_entry[READ_LATENCY-1]) ? NOP_INSTRUCTION
                                                                     : bus.imem_read_data;
  assign pop            = bus.instr_valid && bus.instr_ready;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_data_entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .head_valid (fifo_head_valid),
    .count      (fifo_count)
  );

  assign bus.pc_ready           = pc_ready;
  assign bus.load_active        = load_active_q;
  assign bus.instr_valid        = fifo_head_valid && !reset;
  assign bus.instr_data         = bus.instr_valid ? fifo_head.data : '0;
  assign bus.instr_pc           = bus.instr_valid ? fifo_head.tag.pc : '0;
  assign bus.instr_misaligned   = bus.instr_valid && fifo_head.tag.misaligned;
  assign bus.instr_out_of_range = bus.instr_valid && fifo_head.tag.out_of_range;

  // Memory port: loader owns it in LOAD, otherwise only valid reads drive it
  always_comb begin
    bus.imem_read_enable  = 1'b0;
    bus.imem_write_enable = 1'b0;
    bus.imem_address      = '0;
    bus.imem_write_data   = '0;
    if (!reset) begin
      if (state == LOAD) begin
        bus.imem_write_enable = bus.load_write;
        bus.imem_address      = bus.load_address[AW-1:2];
        bus.imem_write_data   = bus.load_data;
      end else if (read_enable) begin
        bus.imem_read_enable = 1'b1;
        bus.imem_address     = bus.pc_address[AW-1:2];
      end
    end
  end

  assign unused_load_bits = ^{bus.load_address[31:AW], bus.load_address[1:0]};

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// tb/tb_instruction_fetch_buffer.sv - randomized self-checking bench with a transaction-level model
module tb_instruction_fetch_buffer;
  localparam int          MEMORY_SIZE  = 1024;
  localparam int          AW           = 10;
  localparam int          READ_LATENCY = 2;
  localparam int          FIFO_DEPTH   = 4;
  localparam logic [31:0] NOP          = 32'h00000013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_buffer_if #(.ADDR_W(AW - 2)) bus ();

  instruction_fetch_buffer #(
    .MEMORY_SIZE         (MEMORY_SIZE),
    .MEMORY_ADDRESS_BITS (AW),
    .READ_LATENCY        (READ_LATENCY),
    .FIFO_DEPTH          (FIFO_DEPTH),
    .NOP_INSTRUCTION     (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory with fixed read latency; contents preloaded from ref_mem, then written only by the DUT
  logic [31:0]             mem     [256];
  logic [31:0]             ref_mem [256];
  logic [READ_LATENCY-1:0] rd_v;
  logic [7:0]              rd_a    [READ_LATENCY];
  bit                      preload;

  always @(posedge clk) begin
    if (preload) begin
      rd_v <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else begin
      rd_v[0] <= bus.imem_read_enable;
      rd_a[0] <= bus.imem_address;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_v[i] <= rd_v[i-1];
        rd_a[i] <= rd_a[i-1];
      end
      if (bus.imem_write_enable) mem[bus.imem_address] <= bus.imem_write_data;
    end
  end

  assign bus.imem_read_data = rd_v[READ_LATENCY-1] ? mem[rd_a[READ_LATENCY-1]] : 32'hBADBAD00;

  // Reference: every accepted fetch, in program order, with the cycle it becomes visible
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        mis;
    logic        oor;
    int          rdy;
  } exp_t;

  exp_t q[$];
  int   cycle;
  int   checks;
  int   passes;
  int   mstate;      // 0 fetching, 1 draining, 2 loading
  bit   last_accept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
  endtask

  function automatic logic [31:0] rand_pc();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return ($urandom_range(0, 1023) & 32'hFFFF_FFFC) | $urandom_range(1, 3);
    if (r == 1) return 32'h0000_0400 + ($urandom_range(0, 255) << 2);
    if (r == 2) return 32'h8000_0000 | ($urandom & 32'hFFFF_FFFC);
    return $urandom_range(0, 255) << 2;
  endfunction

  // One clock: sample and check at the falling edge, advance the model, resume after the rising edge
  task automatic step();
    bit          exp_ready;
    bit          exp_valid;
    bit          fault;
    int          inflight;
    exp_t        e;
    logic [31:0] pc;
    @(negedge clk);
    if (reset) begin
      check("rst_rd_en", bus.imem_read_enable, 0);
      check("rst_wr_en", bus.imem_write_enable, 0);
      check("rst_pc_ready", bus.pc_ready, 0);
      check("rst_instr_valid", bus.instr_valid, 0);
      q.delete();
      mstate      = 0;
      last_accept = 0;
    end else begin
      inflight = 0;
      foreach (q[i]) if (q[i].rdy > cycle) inflight++;
      exp_ready = (mstate == 0) && !bus.flush && (q.size() < FIFO_DEPTH);
      check("pc_ready", bus.pc_ready, exp_ready);
      check("load_active", bus.load_active, mstate == 2);
      exp_valid = q.size() > 0 && q[0].rdy <= cycle;
      check("instr_valid", bus.instr_valid, exp_valid);
      if (exp_valid) begin
        check("instr_pc", bus.instr_pc, q[0].pc);
        check("instr_data", bus.instr_data, q[0].data);
        check("instr_misaligned", bus.instr_misaligned, q[0].mis);
        check("instr_out_of_range", bus.instr_out_of_range, q[0].oor);
      end
      last_accept = bus.pc_valid && bus.pc_ready;
      if (bus.pc_valid && exp_ready) begin
        pc     = bus.pc_address;
        e.pc   = pc;
        e.mis  = pc[1:0] != 2'b00;
        e.oor  = pc >= 32'(MEMORY_SIZE);
        fault  = e.mis || e.oor;
        e.data = fault ? NOP : ref_mem[(pc >> 2) & 255];
        e.rdy  = cycle + READ_LATENCY + 1;
        check("rd_en", bus.imem_read_enable, !fault);
        if (!fault) check("rd_addr", bus.imem_address, (pc >> 2) & 255);
        q.push_back(e);
      end else if (mstate == 2) begin
        check("load_rd_en", bus.imem_read_enable, 0);
        check("load_wr_en", bus.imem_write_enable, bus.load_write);
        if (bus.load_write) begin
          check("load_wr_addr", bus.imem_address, (bus.load_address >> 2) & 255);
          check("load_wr_data", bus.imem_write_data, bus.load_data);
        end
      end else begin
        check("idle_rd_en", bus.imem_read_enable, 0);
        check("idle_wr_en", bus.imem_write_enable, 0);
      end
      if (exp_valid && bus.instr_ready) void'(q.pop_front());
      if (bus.flush && mstate == 0) q.delete();
      case (mstate)
        0: if (bus.load_mode) mstate = 1;
        1: if (inflight == 0) mstate = 2;
        default: if (!bus.load_mode) mstate = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bus.pc_valid   = 1'b1;
    bus.pc_address = pc;
    step();
    bus.pc_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.pc_valid = 1'b0;
    repeat (n) step();
  endtask

  int          acc_cnt;
  int          mode_cycle;
  int          exp_rise;
  logic [31:0] wa;
  logic [31:0] wd;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    preload          = 1'b1;
    reset            = 1'b1;
    cycle            = 0;
    checks           = 0;
    passes           = 0;
    mstate           = 0;
    bus.pc_valid     = 1'b0;
    bus.pc_address   = '0;
    bus.flush        = 1'b0;
    bus.instr_ready  = 1'b0;
    bus.load_mode    = 1'b0;
    bus.load_write   = 1'b0;
    bus.load_address = '0;
    bus.load_data    = '0;

    step();
    step();
    check("reset_instr_data", bus.instr_data, 0);
    check("reset_instr_pc", bus.instr_pc, 0);
    check("reset_load_active", bus.load_active, 0);
    check("reset_imem_address", bus.imem_address, 0);
    check("reset_imem_write_data", bus.imem_write_data, 0);
    reset   = 1'b0;
    preload = 1'b0;

    // Back-to-back aligned fetches with decode always ready
    bus.instr_ready = 1'b1;
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    idle(6);

    // Backpressure: only FIFO_DEPTH requests get in, then one per pop
    bus.instr_ready = 1'b0;
    acc_cnt = 0;
    bus.pc_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.pc_address = 32'(i * 4 + 32'h100);
      step();
      if (last_accept) acc_cnt++;
    end
    check("backpressure_accepts", acc_cnt, FIFO_DEPTH);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.pc_address = 32'(i * 4 + 32'h200);
      step();
    end
    idle(8);

    // Faulted PCs keep their place in program order
    fetch(32'h6);
    fetch(32'h10);
    fetch(32'h400);
    fetch(32'hFFFF_FFF0);
    idle(8);

    // Flush kills a read in flight; the next fetch is unaffected
    fetch(32'h20);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    idle(4);
    check("flush_no_output", bus.instr_valid, 0);
    fetch(32'h40);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.pc_valid    = $urandom_range(0, 3) != 0;
      bus.pc_address  = rand_pc();
      bus.instr_ready = $urandom_range(0, 3) != 0;
      bus.flush       = $urandom_range(0, 19) == 0;
      step();
    end
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b1;
    idle(10);

    // Program load after two reads drain
    fetch(32'h0);
    fetch(32'h4);
    bus.load_mode = 1'b1;
    mode_cycle = cycle;
    exp_rise = ((mode_cycle + 1 > cycle - 1 + READ_LATENCY + 1) ? mode_cycle + 1
                                                                : cycle - 1 + READ_LATENCY + 1) + 1;
    for (int k = 0; k < 20 && !bus.load_active; k++) step();
    check("load_rise_cycle", cycle, exp_rise);
    bus.load_write   = 1'b1;
    bus.load_address = 32'h8;
    bus.load_data    = 32'hDEADBEEF;
    #1;
    check("load_wr_en_now", bus.imem_write_enable, 1);
    check("load_wr_addr_now", bus.imem_address, 2);
    check("load_wr_data_now", bus.imem_write_data, 32'hDEADBEEF);
    ref_mem[2] = 32'hDEADBEEF;
    step();
    for (int i = 0; i < 12; i++) begin
      wa = ($urandom_range(16, 255) << 2);
      wd = $urandom;
      bus.load_write   = $urandom_range(0, 1);
      bus.load_address = wa;
      bus.load_data    = wd;
      if (bus.load_write) ref_mem[(wa >> 2) & 255] = wd;
      step();
    end

    // Reset in the middle of a load write drops that write
    bus.load_write   = 1'b1;
    bus.load_address = 32'hC;
    bus.load_data    = 32'h12345678;
    reset            = 1'b1;
    step();
    reset          = 1'b0;
    bus.load_mode  = 1'b0;
    bus.load_write = 1'b0;
    check("after_reset_load_active", bus.load_active, 0);
    check("after_reset_instr_valid", bus.instr_valid, 0);
    check("after_reset_wr_en", bus.imem_write_enable, 0);
    fetch(32'h8);
    fetch(32'hC);
    idle(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
